// File: rtl/id_serial_issue.sv
// Decode-to-execute issue register that serialises syscall / LL-SC bundles:
// drain bubbles, pulse sys_out, then release. Optional macro: ID_SER_PASS_EN.
module id_serial_issue #(
  parameter int LANES  = 1,
  parameter int DATA_W = 32,
  parameter int DRAIN  = 3
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_payload,
  input  logic [LANES-1:0]          in_wen,
  input  logic [LANES*5-1:0]        in_wreg,
  input  logic                      in_serialize,
  input  logic                      in_notify,
  input  logic                      out_stall,
  input  logic                      flush,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_payload,
  output logic [LANES-1:0]          out_wen,
  output logic [LANES*5-1:0]        out_wreg,
  output logic                      sys_out,
  output logic                      want_freeze,
  output logic [1:0]                dbg_state_o,
  output logic [2:0]                dbg_cnt_o
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_NOTIFY, S_RELEASE} state_t;

  localparam logic [2:0] DRAIN_CNT = 3'(DRAIN);

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      notify_q, notify_d;
  logic                      valid_q, valid_d;
  logic [LANES*DATA_W-1:0]   payload_q, payload_d;
  logic [LANES-1:0]          wen_q, wen_d;
  logic [LANES*5-1:0]        wreg_q, wreg_d;
  logic                      sys_q, sys_d;
  logic [LANES-1:0]          wen_masked;

  // Writes to r0 are architecturally discarded, so never forward them.
  always_comb begin
    wen_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      wen_masked[i] = in_wen[i] && (in_wreg[i*5 +: 5] != 5'd0);
    end
  end

  assign in_ready    = !out_stall && !flush && (state_q == S_RUN || state_q == S_RELEASE);
  assign want_freeze = (state_q == S_DRAIN) || (state_q == S_NOTIFY) ||
                       ((state_q == S_RUN) && in_valid && in_serialize);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    notify_d  = notify_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    wen_d     = wen_q;
    wreg_d    = wreg_q;
    sys_d     = 1'b0;
    if (flush) begin
      state_d  = S_RUN;
      cnt_d    = 3'd0;
      notify_d = 1'b0;
      valid_d  = 1'b0;
      wen_d    = '0;
    end else if (!out_stall) begin
      case (state_q)
        S_RUN, S_RELEASE: begin
          state_d = S_RUN;
          if (in_valid && in_serialize) begin
`ifdef ID_SER_PASS_EN
            valid_d   = 1'b1;
            payload_d = in_payload;
            wreg_d    = in_wreg;
`else
            valid_d   = 1'b0;
            payload_d = '0;
            wreg_d    = '0;
`endif
            wen_d    = '0;
            cnt_d    = DRAIN_CNT;
            notify_d = in_notify;
            // The accept slot is itself the first bubble of the drain.
            state_d  = (DRAIN_CNT == 3'd1) ? S_NOTIFY : S_DRAIN;
          end else if (in_valid) begin
            valid_d   = 1'b1;
            payload_d = in_payload;
            wreg_d    = in_wreg;
            wen_d     = wen_masked;
          end else begin
            valid_d = 1'b0;
            wen_d   = '0;
          end
        end
        S_DRAIN: begin
          valid_d = 1'b0;
          wen_d   = '0;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q <= 3'd2) state_d = S_NOTIFY;
        end
        S_NOTIFY: begin
          valid_d = 1'b0;
          wen_d   = '0;
          sys_d   = notify_q;
          state_d = S_RELEASE;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_RUN;
      cnt_q     <= 3'd0;
      notify_q  <= 1'b0;
      valid_q   <= 1'b0;
      payload_q <= '0;
      wen_q     <= '0;
      wreg_q    <= '0;
      sys_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      notify_q  <= notify_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      wen_q     <= wen_d;
      wreg_q    <= wreg_d;
      sys_q     <= sys_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign out_wen     = wen_q;
  assign out_wreg    = wreg_q;
  assign sys_out     = sys_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_serial_issue.sv
// Bench for id_serial_issue: LANES=2, DATA_W=32, DRAIN=3; random plain traffic
// against a bundle-level model plus directed serialise/stall/flush/reset steps.
module tb_id_serial_issue;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int DRAIN  = 3;
  localparam int PW     = LANES * DATA_W;
  localparam int W      = 1 + LANES + LANES * 5 + PW;
`ifdef ID_SER_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              in_valid, in_serialize, in_notify, out_stall, flush;
  logic [PW-1:0]     in_payload;
  logic [LANES-1:0]  in_wen;
  logic [LANES*5-1:0] in_wreg;
  logic              in_ready, out_valid, sys_out, want_freeze;
  logic [PW-1:0]     out_payload;
  logic [LANES-1:0]  out_wen;
  logic [LANES*5-1:0] out_wreg;
  logic [1:0]        dbg_state;
  logic [2:0]        dbg_cnt;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  id_serial_issue #(.LANES(LANES), .DATA_W(DATA_W), .DRAIN(DRAIN)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_payload(in_payload),
    .in_wen(in_wen), .in_wreg(in_wreg), .in_serialize(in_serialize),
    .in_notify(in_notify), .out_stall(out_stall), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_payload(out_payload),
    .out_wen(out_wen), .out_wreg(out_wreg), .sys_out(sys_out),
    .want_freeze(want_freeze), .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A lane's write survives only if its destination is not r0.
  function automatic logic [LANES-1:0] ref_wen(input logic [LANES-1:0] wen,
                                               input logic [LANES*5-1:0] wreg);
    logic [LANES-1:0] r;
    logic [4:0] dst;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      dst  = wreg[i*5 +: 5];
      r[i] = wen[i] & (dst != 5'd0);
    end
    return r;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_serialize = 0; in_notify = 0; out_stall = 0; flush = 0;
    in_wen = '0; in_wreg = '0; in_payload = '0;
  endtask

  task automatic drive_serial(input bit notify);
    in_valid     = 1;
    in_serialize = 1;
    in_notify    = notify;
    in_payload   = {$urandom, $urandom};
    in_wen       = 2'b11;
    in_wreg      = {5'd7, 5'd9};
  endtask

  // Starts at cycle 0 with the bundle presented, ends positioned in the pulse
  // cycle p = DRAIN + 1 + stall_len (the release slot).
  task automatic ser_seq(input bit notify, input int stall_at, input int stall_len,
                         input bit from_release);
    int p;
    drive_serial(notify);
    #1;
    check("ser_accept_ready", in_ready, 1);
    check("ser_freeze_c0", want_freeze, from_release ? 0 : 1);
    step();
    idle_inputs();
    p = DRAIN + 1 + stall_len;
    for (int c = 1; c <= p; c++) begin
      out_stall = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
      #1;
      if (c == 1) check("ser_cnt_load", dbg_cnt, DRAIN);
      if (stall_len > 0 && c == stall_at) check("ser_cnt_at_stall", dbg_cnt, 2);
      check("ser_freeze", want_freeze, (c < p) ? 1 : 0);
      check("ser_ready", in_ready, (c == p) ? 1 : 0);
      check("ser_sys_out", sys_out, (c == p) ? notify : 0);
      check("ser_out_valid", out_valid, (PASS && c == 1) ? 1 : 0);
      check("ser_out_wen", out_wen, 0);
      if (c < p) step();
    end
    out_stall = 0;
  endtask

  task automatic expect_run(input string tag);
    idle_inputs();
    #1;
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_freeze"}, want_freeze, 0);
    check({tag, "_sys"}, sys_out, 0);
    check({tag, "_valid"}, out_valid, 0);
  endtask

  initial begin
    logic m_valid;
    logic [LANES-1:0] m_wen;
    logic [LANES*5-1:0] m_wreg;
    logic [PW-1:0] m_payload;
    logic [W-1:0] e;
    logic [4:0] r0, r1;

    idle_inputs();
    RESET = 0;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_wen", out_wen, 0);
    check("rst_payload", out_payload[63:0], 0);
    check("rst_wreg", out_wreg, 0);
    check("rst_sys", sys_out, 0);
    check("rst_cnt", dbg_cnt, 0);
    check("rst_ready", in_ready, 1);
    step(); step();
    RESET = 1;
    step();

    // wen=11, lane0 -> r5, lane1 -> r0
    in_valid = 1; in_wen = 2'b11; in_wreg = {5'd0, 5'd5}; in_payload = {$urandom, $urandom};
    m_payload = in_payload;
    step();
    check("plain_valid", out_valid, 1);
    check("plain_wen_r0", out_wen, 2'b01);
    check("plain_payload", out_payload, m_payload);

    // random plain traffic with random stalls
    m_valid = out_valid; m_wen = out_wen; m_wreg = out_wreg; m_payload = out_payload;
    for (int k = 0; k < 60; k++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_wen     = LANES'($urandom_range(0, 3));
      r0         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r1         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_wreg    = {r1, r0};
      in_payload = {$urandom, $urandom};
      out_stall  = ($urandom_range(0, 4) == 0);
      #1;
      check("rnd_ready", in_ready, !out_stall);
      check("rnd_freeze", want_freeze, 0);
      if (!out_stall) begin
        if (in_valid) begin
          m_valid = 1; m_wen = ref_wen(in_wen, in_wreg); m_wreg = in_wreg; m_payload = in_payload;
        end else begin
          m_valid = 0; m_wen = '0;
        end
      end
      exp_q.push_back({m_valid, m_wen, m_wreg, m_payload});
      step();
      e = exp_q.pop_front();
      check("rnd_valid", out_valid, e[W-1]);
      check("rnd_wen", out_wen, e[W-2 -: LANES]);
      check("rnd_wreg", out_wreg, e[PW +: LANES*5]);
      check("rnd_payload", out_payload, e[PW-1:0]);
      check("rnd_sys", sys_out, 0);
    end
    idle_inputs();
    step();
    step();

    ser_seq(1, 0, 0, 0);
    step(); expect_run("run_after_n1");
    ser_seq(0, 0, 0, 0);
    step(); expect_run("run_after_n0");
    ser_seq(1, 2, 2, 0);
    step(); expect_run("run_after_stall");
    ser_seq(1, 0, 0, 0);
    ser_seq(1, 0, 0, 1);
    step(); expect_run("run_after_b2b");
    for (int k = 0; k < 3; k++) begin
      ser_seq(1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), 0);
      step(); expect_run("run_after_rnd_ser");
    end

    // flush at cycle 2 of the drain
    drive_serial(1);
    step();
    idle_inputs();
    step();
    flush = 1;
    #1;
    check("flush_ready_low", in_ready, 0);
    step();
    expect_run("post_flush");
    check("post_flush_cnt", dbg_cnt, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("flush_no_pulse", sys_out, 0);
    end

    // reset asserted in the middle of the notify cycle
    drive_serial(1);
    step();
    idle_inputs();
    for (int k = 1; k < DRAIN; k++) step();
    check("pre_rst_freeze", want_freeze, 1);
    #2;
    RESET = 0;
    #1;
    check("midrst_sys", sys_out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_freeze", want_freeze, 0);
    check("midrst_cnt", dbg_cnt, 0);
    step();
    RESET = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rst_no_pulse", sys_out, 0);
      check("rst_ready_after", in_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_serial_issue.md
ID_SERIAL_ISSUE -- requirements
Module: id_serial_issue

Interface
REQ-001 Parameter LANES, default 1: instruction lanes per issue bundle (1..4).
REQ-002 Parameter DATA_W, default 32: payload bits per lane.
REQ-003 Parameter DRAIN, default 3: bubble cycles issued before a serialising notify (1..7).
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  bundle present from decode.
REQ-007 in_payload  input  LANES*DATA_W  decoded lane payloads, lane 0 in LSBs.
REQ-008 in_wen  input  LANES  per-lane register-write request.
REQ-009 in_wreg  input  LANES*5  per-lane destination register.
REQ-010 in_serialize  input  1  bundle is serialising (syscall, LL/SC flush).
REQ-011 in_notify  input  1  serialising bundle must raise sys_out (0 for LL/SC).
REQ-012 out_stall  input  1  downstream cannot accept; hold outputs.
REQ-013 flush  input  1  synchronous kill of pipeline contents and sequence.
REQ-014 in_ready  output  1  bundle accepted this cycle.
REQ-015 out_valid  output  1  registered bundle valid to EXE.
REQ-016 out_payload  output  LANES*DATA_W  registered payload.
REQ-017 out_wen  output  LANES  registered write enables, r0-suppressed.
REQ-018 out_wreg  output  LANES*5  registered destinations.
REQ-019 sys_out  output  1  one-cycle registered notify pulse.
REQ-020 want_freeze  output  1  combinational request for fetch to hold PC.

Function
REQ-021 States RUN, DRAIN, NOTIFY, RELEASE; 3-bit down-counter cnt.
REQ-022 in_ready = !out_stall && !flush && (state==RUN || state==RELEASE).
REQ-023 Accepted non-serialising bundle: next cycle out_valid=in_valid, payload/wreg copied, out_wen[i]=in_wen[i] && in_wreg lane i != 0; latency 1.
REQ-024 Accepted serialising bundle: out_valid=0 (see REQ-033), cnt<=DRAIN, notify flag latched, state<=DRAIN.
REQ-025 DRAIN: each cycle with !out_stall issues a bubble (out_valid=0, out_wen=0) and decrements cnt; cnt==1 moves to NOTIFY.
REQ-026 NOTIFY: sys_out<=latched notify for exactly one cycle; next state RELEASE.
REQ-027 RELEASE: sys_out<=0; serialising bundle accepted here restarts DRAIN (back-to-back), else state<=RUN.
REQ-028 want_freeze = 1 in DRAIN or NOTIFY, or in RUN when in_valid && in_serialize; forced 0 in RELEASE.
REQ-029 out_stall=1: all outputs, state and cnt hold; sys_out never repeats.
REQ-030 flush=1 (priority over all but reset): out_valid=0, out_wen=0, sys_out=0, state<=RUN, cnt<=0, pending notify dropped.
REQ-031 in_valid=0 in RUN with !out_stall: out_valid<=0, out_wen<=0.

Reset
REQ-032 RESET low: state=RUN, cnt=0, notify flag=0, out_valid=0, out_payload=0, out_wen=0, out_wreg=0, sys_out=0, immediately, regardless of CLK; mid-sequence reset abandons sequence.

Configuration
REQ-033 Macro ID_SER_PASS_EN defined: the serialising bundle itself issues in the accept cycle with out_valid=1 and out_wen=0 (lets MEM flush cache); undefined: that slot is a pure bubble with payload zeroed.

Verification
REQ-034 LANES=2, plain bundle wen=11, wreg={5,0} -> next cycle out_valid=1, out_wen=01.
REQ-035 DRAIN=3, serialise notify=1 at cycle 0 -> want_freeze=1 cycles 0-3, bubbles cycles 1-3, sys_out=1 cycle 4 only, want_freeze=0 cycle 4 (RELEASE), RUN cycle 5.
REQ-036 Serialise notify=0 -> identical timing, sys_out stays 0.
REQ-037 out_stall high 2 cycles during DRAIN cnt=2 -> outputs frozen, sys_out pulse shifts by 2 cycles, width 1.
REQ-038 Second serialising bundle presented in RELEASE -> accepted, DRAIN restarts with cnt=3, second sys_out pulse 4 cycles later.
REQ-039 flush at cycle 2 of DRAIN, and separately RESET low mid-NOTIFY -> sys_out=0, out_valid=0, state RUN, in_ready=1 next cycle.
